uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLOCKS_PER_BIT, default 87, meaning clkRx cycles per serial bit; legal range 4..127.
REQ-002 SHALL have port clkRx  input  1  single receive clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port serialIn  input  1  asynchronous serial line, idle high; 8N1, LSB first.
REQ-005 SHALL have port dataOutput  output  8  last correctly framed received byte.
REQ-006 SHALL have port dataValid  output  1  level; high while dataOutput holds an unacknowledged byte.
REQ-007 SHALL have port dataAck  input  1  consumer acknowledge, sampled on posedge clkRx.
REQ-008 SHALL have port frameError  output  1  one-cycle pulse; stop bit sampled low.
REQ-009 SHALL have port overrun  output  1  sticky; a byte was overwritten while still unacknowledged.
REQ-010 SHALL have port busy  output  1  high in every state other than IDLE.

Function
REQ-011 SHALL pass serialIn through a 2-flop synchronizer and SHALL keep a third flop (prev) holding the previous synchronized value; all logic SHALL use only the synchronized value.
REQ-012 SHALL implement states IDLE, START, DATA, STOP with a 7-bit clkCount, a 3-bit bitIndex and an 8-bit shift register.
REQ-013 IDLE: clkCount=0, bitIndex=0; on synchronized 0 with prev 1 (falling edge) SHALL go to START; a line held low SHALL NOT retrigger.
REQ-014 START: SHALL increment clkCount until it equals (CLOCKS_PER_BIT-1)/2 (integer division; 43 at default); on that cycle, synchronized 0 -> DATA with clkCount=0; synchronized 1 -> IDLE (glitch rejected, no outputs change).
REQ-015 DATA: SHALL increment clkCount until it equals CLOCKS_PER_BIT-1; on that cycle SHALL store the synchronized bit at index bitIndex, clear clkCount, and either increment bitIndex or, after index 7, go to STOP.
REQ-016 STOP: SHALL count to CLOCKS_PER_BIT-1 and sample; 1 -> load dataOutput from the shift register, set dataValid; 0 -> pulse frameError for one cycle, leave dataOutput/dataValid unchanged; either case -> IDLE.
REQ-017 dataValid SHALL clear on a posedge where dataAck=1 and no byte is being loaded; dataAck while dataValid=0 SHALL have no effect.
REQ-018 Load and dataAck on the same posedge: new byte SHALL be loaded, dataValid SHALL stay 1, overrun SHALL NOT set.
REQ-019 Load while dataValid=1 and dataAck=0: new byte SHALL overwrite dataOutput and overrun SHALL set.
REQ-020 overrun SHALL clear only on reset or on a posedge with dataAck=1 and no simultaneous overrun condition.
REQ-021 Latency: with edge 0 = first posedge sampling serialIn low, the STOP sample and dataValid/frameError update SHALL occur at edge 3 + (CLOCKS_PER_BIT-1)/2 + 9*CLOCKS_PER_BIT (829 at default).
REQ-022 Reception SHALL be independent of dataValid; the receiver SHALL never stall.

Reset
REQ-023 reset=0 SHALL immediately force IDLE, clkCount=0, bitIndex=0, shift register=0, dataOutput=0x00, dataValid=0, frameError=0, overrun=0, busy=0, synchronizer and prev flops=1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no dataValid or frameError; after release the remaining frame bits SHALL NOT be received as a byte unless a new falling edge is seen.
REQ-025 After release, first state change SHALL occur on a posedge with reset=1.

Verification
REQ-026 Send 0xA5 at 87 clk/bit, dataAck=0 -> dataValid rises at edge 829, dataOutput=0xA5, frameError=0, overrun=0, busy low from edge 830.
REQ-027 Low pulse of 20 cycles on idle line -> back to IDLE at START sample, no dataValid, no frameError.
REQ-028 Send 0x3C with stop bit driven 0 -> frameError high exactly one cycle at edge 829, dataValid stays 0; line then held low 2000 cycles -> no new reception.
REQ-029 Send 0x11 then 0x22 back-to-back, no dataAck -> dataOutput=0x22, dataValid=1, overrun=1; one-cycle dataAck -> dataValid=0, overrun=0.
REQ-030 Send 0x55, assert dataAck on exactly the posedge that loads a following 0x66 -> dataOutput=0x66, dataValid=1, overrun=0.
REQ-031 Assert reset=0 during bit 4 of 0xF0 -> all outputs 0 asynchronously; release with line high -> next frame 0x81 received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, oversampled by CLOCKS_PER_BIT.
//
// Ports:
//   clkRx      - receive clock; all state updates on its rising edge
//   reset      - asynchronous active-low reset
//   serialIn   - asynchronous serial line, idle high
//   dataOutput - last correctly framed byte
//   dataValid  - high while dataOutput holds an unacknowledged byte
//   dataAck    - consumer acknowledge for dataOutput
//   frameError - one-cycle pulse when a stop bit is sampled low
//   overrun    - sticky: an unacknowledged byte was overwritten
//   busy       - high whenever the receiver is not idle
module uart_rx #(
  parameter int unsigned CLOCKS_PER_BIT = 87
) (
  input  logic       clkRx,
  input  logic       reset,
  input  logic       serialIn,
  output logic [7:0] dataOutput,
  output logic       dataValid,
  input  logic       dataAck,
  output logic       frameError,
  output logic       overrun,
  output logic       busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [6:0] LAST_COUNT = 7'(CLOCKS_PER_BIT - 1);
  localparam logic [6:0] HALF_COUNT = 7'((CLOCKS_PER_BIT - 1) / 2);

  logic       sync_meta_q, sync_line_q, prev_line_q;
  logic [1:0] state_q, state_d;
  logic [6:0] clk_count_q, clk_count_d;
  logic [2:0] bit_index_q, bit_index_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       frame_err_q, frame_err_d;
  logic       overrun_q, overrun_d;
  logic       load;

  always_comb begin
    state_d     = state_q;
    clk_count_d = clk_count_q;
    bit_index_d = bit_index_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    load        = 1'b0;

    case (state_q)
      IDLE: begin
        clk_count_d = 7'd0;
        bit_index_d = 3'd0;
        // Edge-triggered so a line stuck low cannot start a new frame.
        if (!sync_line_q && prev_line_q) begin
          state_d = START;
        end
      end
      START: begin
        if (clk_count_q == HALF_COUNT) begin
          clk_count_d = 7'd0;
          // Line back high at mid-start-bit means a glitch, not a frame.
          state_d     = sync_line_q ? IDLE : DATA;
        end else begin
          clk_count_d = clk_count_q + 7'd1;
        end
      end
      DATA: begin
        if (clk_count_q == LAST_COUNT) begin
          clk_count_d          = 7'd0;
          shift_d[bit_index_q] = sync_line_q;
          if (bit_index_q == 3'd7) begin
            bit_index_d = 3'd0;
            state_d     = STOP;
          end else begin
            bit_index_d = bit_index_q + 3'd1;
          end
        end else begin
          clk_count_d = clk_count_q + 7'd1;
        end
      end
      STOP: begin
        if (clk_count_q == LAST_COUNT) begin
          clk_count_d = 7'd0;
          state_d     = IDLE;
          if (sync_line_q) begin
            load = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          clk_count_d = clk_count_q + 7'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    data_d = load ? shift_q : data_q;

    // A load wins over an acknowledge, so valid stays high when both coincide.
    if (load) begin
      valid_d = 1'b1;
    end else if (dataAck) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    if (load && valid_q && !dataAck) begin
      overrun_d = 1'b1;
    end else if (dataAck) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  always_ff @(posedge clkRx or negedge reset) begin
    if (!reset) begin
      sync_meta_q <= 1'b1;
      sync_line_q <= 1'b1;
      prev_line_q <= 1'b1;
      state_q     <= IDLE;
      clk_count_q <= 7'd0;
      bit_index_q <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_meta_q <= serialIn;
      sync_line_q <= sync_meta_q;
      prev_line_q <= sync_line_q;
      state_q     <= state_d;
      clk_count_q <= clk_count_d;
      bit_index_q <= bit_index_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign dataOutput = data_q;
  assign dataValid  = valid_q;
  assign frameError = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule
